// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table checker: drives codes 0..2^N_IN-1, holds each HOLD_CYCLES clocks, compares dut_q to EXP_TABLE.
// Latency: result on edge start+2^N_IN*HOLD_CYCLES; optional STOP_ON_FAIL_EN ends the sweep at the first mismatch.
// Backpressure: none; start is only honoured in IDLE or DONE and ignored while busy.
module truth_table_sweeper #(
  parameter int                   N_IN        = 3,
  parameter int                   HOLD_CYCLES = 4,
  parameter logic [(1<<N_IN)-1:0] EXP_TABLE   = 8'hE8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_q,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [N_IN-1:0] LAST_IDX  = N_IN'((1 << N_IN) - 1);
  localparam logic [HW-1:0]   LAST_HOLD = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [N_IN:0]   err_q, err_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffi_q, ffi_d;
  logic            pass_q, pass_d;
  logic            mismatch;
  logic            sweep_end;

  assign mismatch = (dut_q != EXP_TABLE[idx_q]);

`ifdef STOP_ON_FAIL_EN
  assign sweep_end = (idx_q == LAST_IDX) || mismatch;
`else
  assign sweep_end = (idx_q == LAST_IDX);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_APPLY;
          idx_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_APPLY: begin
        if (hold_q == LAST_HOLD) begin
          hold_d = '0;
          if (mismatch) begin
            err_d = err_q + (N_IN+1)'(1);
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = idx_q;
            end
          end
          // pass must see the mismatch counted on this very edge
          if (sweep_end) begin
            state_d = S_DONE;
            pass_d  = (err_d == '0);
          end else begin
            idx_d = idx_q + N_IN'(1);
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stim             = idx_q;
  assign busy             = (state_q == S_APPLY);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench: majority DUT (3-in, hold 4) and XOR DUT (2-in, hold 1) with random per-code fault masks.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] stim;
  logic       dut_q;
  logic       busy, done, pass, ffv;
  logic [3:0] err;
  logic [2:0] ffi;
  logic [7:0] mask = 8'h00;

  logic       start2 = 1'b0;
  logic [1:0] stim2;
  logic       dut_q2;
  logic       busy2, done2, pass2, ffv2;
  logic [2:0] err2;
  logic [1:0] ffi2;
  logic [3:0] mask2 = 4'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Bench DUTs: ideal function with selected codes inverted by the fault mask
  assign dut_q  = (($countones(stim) >= 2) ? 1'b1 : 1'b0) ^ mask[stim];
  assign dut_q2 = (^stim2) ^ mask2[stim2];

  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(4), .EXP_TABLE(8'hE8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .dut_q(dut_q),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_fail_valid(ffv), .first_fail_idx(ffi)
  );

  truth_table_sweeper #(.N_IN(2), .HOLD_CYCLES(1), .EXP_TABLE(4'h6)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .stim(stim2), .dut_q(dut_q2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_valid(ffv2), .first_fail_idx(ffi2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int faults_below(input logic [7:0] m, input int c);
    int n = 0;
    for (int i = 0; i < c && i < 8; i++) n += m[i] ? 1 : 0;
    return n;
  endfunction

  // One full sweep of the 3-input DUT; start is pulsed again at offset ignore_at (if >0)
  task automatic run_sweep(input logic [7:0] m, input int ignore_at);
    int first, tend, exp_err, exp_stim;
    mask  = m;
    first = -1;
    for (int i = 7; i >= 0; i--) if (m[i]) first = i;
`ifdef STOP_ON_FAIL_EN
    tend     = (first < 0) ? 32 : 4 * (first + 1);
    exp_err  = (first < 0) ? 0 : 1;
    exp_stim = (first < 0) ? 7 : first;
`else
    tend     = 32;
    exp_err  = $countones(m);
    exp_stim = 7;
`endif
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = (ignore_at == 1);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
    chk("start_ffv", ffv, 0);
    chk("start_stim", stim, 0);
    for (int t = 1; t < tend; t++) begin
      @(negedge clk) start = (t + 1 == ignore_at);
      chk("run_stim", stim, t / 4);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_err", err, faults_below(m, t / 4));
    end
    @(negedge clk) start = 1'b0;
    chk("end_busy", busy, 0);
    chk("end_done", done, 1);
    chk("end_pass", pass, (first < 0) ? 1 : 0);
    chk("end_err", err, exp_err);
    chk("end_ffv", ffv, (first < 0) ? 0 : 1);
    if (first >= 0) chk("end_ffi", ffi, first);
    chk("end_stim", stim, exp_stim);
    @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_stim", stim, exp_stim);
  endtask

  initial begin
    logic [7:0] rm;
    logic [3:0] m2;
    int         f2;

    repeat (2) @(negedge clk);
    chk("rst_stim", stim, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_ffv", ffv, 0);
    chk("rst_ffi", ffi, 0);
    chk("rst_stim2", stim2, 0);
    rst = 1'b0;
    @(negedge clk);

    run_sweep(8'h00, 0);
    run_sweep(8'h60, 0);
    // restart directly from a failing DONE, with an extra start mid-sweep that must be ignored
    run_sweep(8'h00, 10);
    for (int r = 0; r < 4; r++) begin
      rm = 8'($urandom);
      run_sweep(rm, 0);
    end
    run_sweep(8'h80, 0);

    // asynchronous reset mid-sweep
    mask = 8'h01;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_rst_stim", stim, 3);
    #1 rst = 1'b1;
    #1;
    chk("arst_stim", stim, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_ffv", ffv, 0);
    @(negedge clk) rst = 1'b0;
    run_sweep(8'h00, 0);

    // 2-input XOR, hold 1: result four clocks after the accepting edge
    for (int r = 0; r < 3; r++) begin
      m2 = (r == 0) ? 4'h0 : 4'($urandom);
      mask2 = m2;
      f2 = -1;
      for (int i = 3; i >= 0; i--) if (m2[i]) f2 = i;
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      chk("x_start_stim", stim2, 0);
      chk("x_start_busy", busy2, 1);
`ifdef STOP_ON_FAIL_EN
      for (int t = 1; t < ((f2 < 0) ? 4 : f2 + 1); t++) begin
`else
      for (int t = 1; t < 4; t++) begin
`endif
        @(negedge clk);
        chk("x_run_stim", stim2, t);
        chk("x_run_done", done2, 0);
      end
      @(negedge clk);
      chk("x_end_done", done2, 1);
      chk("x_end_busy", busy2, 0);
      chk("x_end_pass", pass2, (m2 == 4'h0) ? 1 : 0);
`ifdef STOP_ON_FAIL_EN
      chk("x_end_err", err2, (f2 < 0) ? 0 : 1);
`else
      chk("x_end_err", err2, $countones(m2));
`endif
      if (f2 >= 0) chk("x_end_ffi", ffi2, f2);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
